// File: rtl/chip_pkg.sv
// Shared constants and FSM state encoding for the reg_arbiter register file.
package chip_pkg;

  localparam int unsigned REGCOUNT = 20;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I2C = 2'd1,
    GNT_PAR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector: requester b wins a tie only if a was granted last.
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_advance,
  output logic o_sel_b,
  output logic o_any
);

  logic r_last_b;

  always_comb begin
    o_any   = i_req_a | i_req_b;
    o_sel_b = i_req_b & (~i_req_a | ~r_last_b);
  end

  // Reset as "b granted last" so requester a has priority out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_b <= 1'b1;
    end else if (i_advance) begin
      r_last_b <= o_sel_b;
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Register file shared between an I2C port and a parallel-capture port, one access per grant.
// Optional macro REG_LOCK_EN: register 0 bit 7 locks out parallel writes while set.
module reg_arbiter #(
  parameter int unsigned REGCOUNT = chip_pkg::REGCOUNT,
  parameter int unsigned DATA_W   = chip_pkg::DATA_W,
  parameter int unsigned ADDR_W   = chip_pkg::ADDR_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i2c_req,
  input  logic                       i2c_we,
  input  logic [ADDR_W-1:0]          i2c_addr,
  input  logic [DATA_W-1:0]          i2c_wdata,
  output logic                       i2c_gnt,
  output logic [DATA_W-1:0]          i2c_rdata,
  input  logic                       par_req,
  input  logic [ADDR_W-1:0]          par_addr,
  input  logic [DATA_W-1:0]          par_data,
  output logic                       par_gnt,
  output logic                       err,
  output logic [DATA_W*REGCOUNT-1:0] registers_packed
);

  import chip_pkg::*;

  localparam logic [ADDR_W:0] LP_REGCOUNT = (ADDR_W+1)'(REGCOUNT);

  logic [DATA_W-1:0] r_regs [REGCOUNT];
  arb_state_t        r_state;
  arb_state_t        w_state_d;
  logic              r_i2c_smp;
  logic              r_par_smp;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_any;
  logic              w_sel_par;
  logic              w_acc_i2c;
  logic              w_acc_par;
  logic              w_i2c_ok;
  logic              w_par_ok;
  logic              w_locked;
  logic              w_wr_en;
  logic              w_err_d;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_rd_val;

  rr_arb2 u_rr_arb2 (
    .clock     (clock),
    .reset     (reset),
    .i_req_a   (r_i2c_smp),
    .i_req_b   (r_par_smp),
    .i_advance (w_acc_i2c | w_acc_par),
    .o_sel_b   (w_sel_par),
    .o_any     (w_any)
  );

`ifdef REG_LOCK_EN
  assign w_locked = r_regs[0][7];
`else
  assign w_locked = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_d = w_sel_par ? GNT_PAR : GNT_I2C;
        end
      end
      GNT_I2C: w_state_d = IDLE;
      GNT_PAR: w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // The access itself happens on the IDLE-to-GNT edge using the live request fields.
  always_comb begin
    w_acc_i2c = (r_state == IDLE) & w_any & ~w_sel_par;
    w_acc_par = (r_state == IDLE) & w_any & w_sel_par;
    w_i2c_ok  = ({1'b0, i2c_addr} < LP_REGCOUNT);
    w_par_ok  = ({1'b0, par_addr} < LP_REGCOUNT) & ~w_locked;
    w_wr_en   = (w_acc_i2c & i2c_we & w_i2c_ok) | (w_acc_par & w_par_ok);
    w_wr_addr = w_acc_par ? par_addr : i2c_addr;
    w_wr_data = w_acc_par ? par_data : i2c_wdata;
    w_err_d   = (w_acc_i2c & ~w_i2c_ok) | (w_acc_par & ~w_par_ok);
    w_rd_val  = '1;
    if (w_i2c_ok) begin
      w_rd_val = r_regs[i2c_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGCOUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // A just-granted side's sample is cleared so its still-high request is not reused.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_i2c_smp <= 1'b0;
      r_par_smp <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_i2c_smp <= (r_state == GNT_I2C) ? 1'b0 : i2c_req;
      r_par_smp <= (r_state == GNT_PAR) ? 1'b0 : par_req;
      r_err     <= w_err_d;
      if (w_acc_i2c && !i2c_we) begin
        r_rdata <= w_rd_val;
      end
    end
  end

  assign i2c_gnt   = (r_state == GNT_I2C);
  assign par_gnt   = (r_state == GNT_PAR);
  assign err       = r_err;
  assign i2c_rdata = r_rdata;

  for (genvar g = 0; g < REGCOUNT; g++) begin : g_pack
    assign registers_packed[DATA_W*g +: DATA_W] = r_regs[g];
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter with a grant scoreboard; REG_LOCK_EN selects the lock checks.
module tb_reg_arbiter;

  import chip_pkg::*;

  localparam int unsigned PW = DATA_W * REGCOUNT;

  typedef struct {
    bit         par;
    bit         we;
    logic [4:0] addr;
    logic [7:0] data;
  } req_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i2c_req = 1'b0;
  logic          i2c_we = 1'b0;
  logic [4:0]    i2c_addr = '0;
  logic [7:0]    i2c_wdata = '0;
  logic          i2c_gnt;
  logic [7:0]    i2c_rdata;
  logic          par_req = 1'b0;
  logic [4:0]    par_addr = '0;
  logic [7:0]    par_data = '0;
  logic          par_gnt;
  logic          err;
  logic [PW-1:0] registers_packed;

  req_t          exp_q[$];
  logic [PW-1:0] model = '0;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;

  reg_arbiter u_dut (
    .clock            (clock),
    .reset            (reset),
    .i2c_req          (i2c_req),
    .i2c_we           (i2c_we),
    .i2c_addr         (i2c_addr),
    .i2c_wdata        (i2c_wdata),
    .i2c_gnt          (i2c_gnt),
    .i2c_rdata        (i2c_rdata),
    .par_req          (par_req),
    .par_addr         (par_addr),
    .par_data         (par_data),
    .par_gnt          (par_gnt),
    .err              (err),
    .registers_packed (registers_packed)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [PW-1:0] o, input logic [PW-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chkb(input string tag, input logic o, input logic e);
    chk(tag, PW'(o), PW'(e));
  endtask

  task automatic chk8(input string tag, input logic [7:0] o, input logic [7:0] e);
    chk(tag, PW'(o), PW'(e));
  endtask

  task automatic chki(input string tag, input int o, input int e);
    chk(tag, PW'(o), PW'(e));
  endtask

  // Scoreboard: every grant pops the oldest expected request and is checked against the model.
  always @(negedge clock) begin
    req_t       e;
    logic       ok;
    logic       lk;
    if (i2c_gnt || par_gnt) begin
      chkb("gnt_one_side", i2c_gnt & par_gnt, 1'b0);
      chkb("gnt_queued", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        ok = (e.addr < REGCOUNT);
        lk = 1'b0;
`ifdef REG_LOCK_EN
        lk = e.par && model[7];
`endif
        chkb("gnt_side", par_gnt, e.par);
        chkb("gnt_err", err, !ok || lk);
        if ((e.par || e.we) && ok && !lk) model[8*e.addr +: 8] = e.data;
        if (!e.par && !e.we) chk8("gnt_rdata", i2c_rdata, ok ? model[8*e.addr +: 8] : 8'hFF);
        chk("gnt_regs", registers_packed, model);
      end
    end else begin
      chkb("err_idle", err, 1'b0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit par, input bit we, input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back('{par: par, we: we, addr: a, data: d});
    if (par) begin
      par_req = 1'b1; par_addr = a; par_data = d;
    end else begin
      i2c_req = 1'b1; i2c_we = we; i2c_addr = a; i2c_wdata = d;
    end
  endtask

  task automatic wait_gnt(input bit par, output int lat, output int at);
    bit seen = 1'b0;
    lat = 0;
    at  = 0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clock);
      if (par ? par_gnt : i2c_gnt) begin
        seen = 1'b1;
        at   = cyc;
      end else begin
        lat++;
      end
    end
    chkb(par ? "tmo_par" : "tmo_i2c", seen, 1'b1);
  endtask

  task automatic release_req(input bit par);
    step();
    if (par) par_req = 1'b0;
    else i2c_req = 1'b0;
  endtask

  task automatic access(input bit par, input bit we, input logic [4:0] a, input logic [7:0] d);
    int lat;
    int at;
    issue(par, we, a, d);
    wait_gnt(par, lat, at);
    chki("lat_access", lat, 2);
    release_req(par);
  endtask

  initial begin
    int lat;
    int c1;
    int c2;
    int c3;
    int c4;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chkb("rst_i2c_gnt", i2c_gnt, 1'b0);
    chkb("rst_par_gnt", par_gnt, 1'b0);
    chkb("rst_err", err, 1'b0);
    chk8("rst_rdata", i2c_rdata, 8'h00);
    chk("rst_regs", registers_packed, '0);
    step();
    reset = 1'b0;

    issue(1'b0, 1'b1, 5'd3, 8'hA5);
    wait_gnt(1'b0, lat, c1);
    chki("lat_wr3", lat, 2);
    chk8("reg3_in_gnt", registers_packed[31:24], 8'hA5);
    release_req(1'b0);

    // Fields changed during the grant cycle must not affect the captured access.
    issue(1'b0, 1'b1, 5'd4, 8'h44);
    wait_gnt(1'b0, lat, c1);
    i2c_addr  = 5'd6;
    i2c_wdata = 8'hEE;
    release_req(1'b0);
    @(negedge clock);
    chk8("capt_reg4", registers_packed[39:32], 8'h44);
    chk8("capt_reg6", registers_packed[55:48], 8'h00);
    step();

    access(1'b0, 1'b1, 5'd19, 8'h3C);
    issue(1'b0, 1'b0, 5'd19, 8'h00);
    wait_gnt(1'b0, lat, c1);
    chk8("rd19", i2c_rdata, 8'h3C);
    chkb("rd19_err", err, 1'b0);
    release_req(1'b0);
    access(1'b0, 1'b1, 5'd8, 8'h5E);
    chk8("rdata_hold", i2c_rdata, 8'h3C);
    issue(1'b0, 1'b0, 5'd20, 8'h00);
    wait_gnt(1'b0, lat, c1);
    chk8("rd20", i2c_rdata, 8'hFF);
    chkb("rd20_err", err, 1'b1);
    release_req(1'b0);

    issue(1'b1, 1'b1, 5'd25, 8'h5A);
    wait_gnt(1'b1, lat, c1);
    chkb("p25_err", err, 1'b1);
    chk("p25_regs", registers_packed, model);
    release_req(1'b1);
    issue(1'b1, 1'b1, 5'd7, 8'h77);
    wait_gnt(1'b1, lat, c1);
    chki("lat_p7", lat, 2);
    chk8("p7_reg", registers_packed[63:56], 8'h77);
    chkb("p7_err", err, 1'b0);
    release_req(1'b1);

    access(1'b0, 1'b1, 5'd0, 8'h80);
    issue(1'b1, 1'b1, 5'd1, 8'h31);
    wait_gnt(1'b1, lat, c1);
`ifdef REG_LOCK_EN
    chkb("lock_err", err, 1'b1);
    chk8("lock_reg1", registers_packed[15:8], 8'h00);
    release_req(1'b1);
    access(1'b0, 1'b1, 5'd0, 8'h00);
    issue(1'b1, 1'b1, 5'd1, 8'h31);
    wait_gnt(1'b1, lat, c1);
    chkb("unlock_err", err, 1'b0);
    chk8("unlock_reg1", registers_packed[15:8], 8'h31);
`else
    chkb("nolock_err", err, 1'b0);
    chk8("nolock_reg1", registers_packed[15:8], 8'h31);
`endif
    release_req(1'b1);

    // Both sides held from reset: I2C first, then strict alternation every two cycles.
    reset = 1'b1;
    issue(1'b0, 1'b1, 5'd5, 8'h11);
    issue(1'b1, 1'b1, 5'd5, 8'h22);
    exp_q.push_back('{par: 1'b0, we: 1'b1, addr: 5'd5, data: 8'h11});
    exp_q.push_back('{par: 1'b1, we: 1'b1, addr: 5'd5, data: 8'h22});
    step();
    model = '0;
    step();
    reset = 1'b0;
    wait_gnt(1'b0, lat, c1);
    chki("both_first_lat", lat, 2);
    wait_gnt(1'b1, lat, c2);
    wait_gnt(1'b0, lat, c3);
    release_req(1'b0);
    wait_gnt(1'b1, lat, c4);
    release_req(1'b1);
    chki("alt_gap1", c2 - c1, 2);
    chki("alt_gap2", c3 - c2, 2);
    chki("alt_gap3", c4 - c3, 2);
    chk8("both_reg5", registers_packed[47:40], 8'h22);

    // Reset during the grant cycle of a write wins.
    issue(1'b0, 1'b1, 5'd2, 8'h99);
    wait_gnt(1'b0, lat, c1);
    reset = 1'b1;
    step();
    reset   = 1'b0;
    i2c_req = 1'b0;
    model   = '0;
    @(negedge clock);
    chk8("rstg_reg2", registers_packed[23:16], 8'h00);
    chkb("rstg_i2c_gnt", i2c_gnt, 1'b0);
    chk("rstg_regs", registers_packed, '0);
    chk8("rstg_rdata", i2c_rdata, 8'h00);
    step();
    access(1'b0, 1'b0, 5'd2, 8'h00);

    chki("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 SHALL have parameter REGCOUNT, default 20, number of 8-bit registers.
REQ-002 SHALL have parameter DATA_W, default 8, register width.
REQ-003 SHALL have parameter ADDR_W, default 5, address width; ADDR_W >= clog2(REGCOUNT).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i2c_req  input  1  I2C-side access request; held until granted.
REQ-007 i2c_we  input  1  1 = write, 0 = read; stable while i2c_req is high.
REQ-008 i2c_addr  input  ADDR_W  I2C-side register address.
REQ-009 i2c_wdata  input  DATA_W  I2C-side write data.
REQ-010 i2c_gnt  output  1  one-cycle grant pulse for the I2C side.
REQ-011 i2c_rdata  output  DATA_W  read data, valid in the i2c_gnt cycle.
REQ-012 par_req  input  1  parallel-capture write request; held until granted.
REQ-013 par_addr  input  ADDR_W  capture target address.
REQ-014 par_data  input  DATA_W  parallel input byte to capture.
REQ-015 par_gnt  output  1  one-cycle grant pulse for the parallel side.
REQ-016 err  output  1  one-cycle pulse: the granted access was rejected.
REQ-017 registers_packed  output  DATA_W*REGCOUNT  register i at bits [DATA_W*i +: DATA_W].

Function
REQ-018 Register file SHALL be owned by this block; registers_packed SHALL reflect register contents directly from flops.
REQ-019 FSM states SHALL be IDLE, GNT_I2C and GNT_PAR.
REQ-020 IDLE SHALL sample requests each cycle and go to GNT_I2C or GNT_PAR on the next edge; with no request it SHALL stay in IDLE.
REQ-021 GNT_I2C and GNT_PAR SHALL last one cycle, assert the matching gnt, and return to IDLE; throughput is one access per 2 cycles.
REQ-022 Both requests in IDLE SHALL be resolved round-robin: the side not granted last wins; after reset the I2C side has priority.
REQ-023 Granted writes SHALL update the register on the same edge that raises gnt, so the new value is visible in registers_packed in the gnt cycle.
REQ-024 Granted I2C reads SHALL drive i2c_rdata with the register value in the gnt cycle; i2c_rdata SHALL hold its value otherwise.
REQ-025 Address >= REGCOUNT SHALL drop a write, return 8'hFF on a read, and pulse err with gnt.
REQ-026 Request fields SHALL be captured at the IDLE-to-GNT edge; later changes SHALL not affect the access.
REQ-027 A request still high in the cycle after gnt SHALL count as a new request.

Reset
REQ-028 On reset: all registers 0, i2c_gnt/par_gnt/err 0, i2c_rdata 0, state IDLE, round-robin pointer set so the I2C side has priority.
REQ-029 Reset during GNT_* SHALL win; a write on that edge SHALL not take effect.

Configuration
REQ-030 With macro REG_LOCK_EN defined, register 0 bit 7 SHALL be a lock bit: while it is 1, parallel writes SHALL be dropped, with par_gnt and err pulsed; I2C access is unaffected.
REQ-031 Without REG_LOCK_EN, register 0 bit 7 SHALL be an ordinary bit with no lock behaviour.

Structure
REQ-032 Package chip_pkg SHALL hold the REGCOUNT, DATA_W and ADDR_W constants and the arb_state_t enum (IDLE, GNT_I2C, GNT_PAR).
REQ-033 Round-robin selection SHALL be a sub-module rr_arb2 (two requesters, last-grant pointer, grant-select output).

Verification
REQ-034 I2C write addr 3, data 8'hA5 -> i2c_gnt 2 cycles after req rises; registers_packed[31:24] = 8'hA5 in the gnt cycle.
REQ-035 Both requests held from reset, I2C writes 8'h11 and parallel writes 8'h22 to addr 5 -> I2C granted first, then parallel; final reg5 = 8'h22; grants alternate while both are held.
REQ-036 I2C read addr 19 after writing 8'h3C -> i2c_rdata = 8'h3C with i2c_gnt; read addr 20 -> 8'hFF with err pulse.
REQ-037 Parallel write addr 25 -> par_gnt and err pulse; no register changes.
REQ-038 REG_LOCK_EN defined: I2C writes reg0 = 8'h80, then parallel write addr 1 -> par_gnt and err pulse, reg1 unchanged; I2C writes reg0 = 8'h00, parallel write succeeds.
REQ-039 Reset asserted in the GNT_I2C cycle of a write to addr 2 -> reg2 = 0, gnt low, state IDLE on the next cycle.
